// File: rtl/game_manager_nxn_if.sv
// game_manager_nxn_if: button inputs and board/status outputs of the NxN game engine
//  master: button front-end / testbench side (drives pulses, reads board state)
//  slave : game engine side
//  btn_u/d/l/r, btn_s, btn_undo, new_game : single-cycle pulses into the engine
//  p1_grid, p2_grid (N*N), cursor_x/y (CW), game_state (3), move_count (7), illegal (1) : engine outputs
interface game_manager_nxn_if #(
  parameter int N = 3
);
  localparam int CW = $clog2(N);
  logic btn_u, btn_d, btn_l, btn_r, btn_s, btn_undo, new_game;
  logic [N*N-1:0] p1_grid, p2_grid;
  logic [CW-1:0] cursor_x, cursor_y;
  logic [2:0] game_state;
  logic [6:0] move_count;
  logic illegal;
  modport master (
    output btn_u, btn_d, btn_l, btn_r, btn_s, btn_undo, new_game,
    input  p1_grid, p2_grid, cursor_x, cursor_y, game_state, move_count, illegal
  );
  modport slave (
    input  btn_u, btn_d, btn_l, btn_r, btn_s, btn_undo, new_game,
    output p1_grid, p2_grid, cursor_x, cursor_y, game_state, move_count, illegal
  );
endinterface

// File: rtl/game_manager_nxn.sv
// game_manager_nxn: NxN board, K-in-a-row turn-based game engine with a sequential win-line walker
//  clk, rst : clock, asynchronous active-high reset
//  bus      : game_manager_nxn_if.slave (button pulses in; grids, cursor, state, move count, illegal out)
//  game_state: 0 P1_TURN, 1 P2_TURN, 2 DRAW, 3 P1_WIN, 4 P2_WIN, 5 CHECK
//  GAME_MGR_UNDO_EN: when defined, one-level undo of the last placed move via btn_undo
//  After a placement the state reads CHECK for 8*(K-1) cycles; the edge closing the final
//  walk step resolves the outcome.
module game_manager_nxn #(
  parameter int N = 3,
  parameter int K = 3
) (
  input logic clk,
  input logic rst,
  game_manager_nxn_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam int IW = $clog2(N * N);
  localparam int PW = CW + 2;
  localparam logic [3:0] KR = 4'(K);
  localparam logic [6:0] NN = 7'(N * N);
  localparam logic [CW-1:0] XM = CW'(N - 1);
  typedef enum logic [2:0] {P1_TURN, P2_TURN, DRAW, P1_WIN, P2_WIN, CHECK} state_t;
  state_t st;
  logic [N*N-1:0] g1, g2;
  logic [CW-1:0] cx, cy, wx, wy;
  logic signed [PW-1:0] px, py;
  logic [6:0] cnt;
  logic [2:0] sc;
  logic [1:0] dir;
  logic [3:0] run, run_n;
  logic mover, back, live, won, ill, hit, half_end, last, win_now;
  logic [IW-1:0] cidx, pidx;
  int dx, dy, nx, ny;
`ifdef GAME_MGR_UNDO_EN
  logic lv, lm;
  logic [IW-1:0] lc;
`else
  logic unused_undo;
  assign unused_undo = bus.btn_undo;
`endif
  // Probe = current walk position plus one step; directions are row, column, diagonal,
  // anti-diagonal (y decreasing going forward), negated on the backward half.
  always_comb begin
    dx = (dir == 2'd1) ? 0 : (back ? -1 : 1);
    dy = (dir == 2'd0) ? 0 : (((dir == 2'd3) != back) ? -1 : 1);
    nx = int'(px) + dx;
    ny = int'(py) + dy;
    pidx = IW'(ny * N + nx);
    cidx = IW'(int'(cy) * N + int'(cx));
    hit = live && nx >= 0 && nx < N && ny >= 0 && ny < N && (mover ? g2[pidx] : g1[pidx]);
    run_n = run + {3'b000, hit};
    half_end = sc == 3'(K - 2);
    last = half_end && back && dir == 2'd3;
    win_now = won || run_n >= KR;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= P1_TURN;
      g1 <= '0;
      g2 <= '0;
      cx <= '0;
      cy <= '0;
      cnt <= '0;
      ill <= 1'b0;
      wx <= '0;
      wy <= '0;
      px <= '0;
      py <= '0;
      dir <= '0;
      sc <= '0;
      run <= '0;
      mover <= 1'b0;
      back <= 1'b0;
      live <= 1'b0;
      won <= 1'b0;
`ifdef GAME_MGR_UNDO_EN
      lv <= 1'b0;
      lm <= 1'b0;
      lc <= '0;
`endif
    end else begin
      ill <= 1'b0;
      if (bus.new_game) begin
        st <= P1_TURN;
        g1 <= '0;
        g2 <= '0;
        cx <= '0;
        cy <= '0;
        cnt <= '0;
`ifdef GAME_MGR_UNDO_EN
        lv <= 1'b0;
`endif
      end else if (st == CHECK) begin
        // A miss or edge kills the walk; the remaining steps of the half still take a cycle each.
        run <= run_n;
        live <= hit;
        sc <= sc + 3'd1;
        if (hit) begin
          px <= PW'(nx);
          py <= PW'(ny);
        end
        if (half_end) begin
          px <= {2'b00, wx};
          py <= {2'b00, wy};
          live <= 1'b1;
          sc <= '0;
          back <= ~back;
          if (back) begin
            dir <= dir + 2'd1;
            run <= 4'd1;
            won <= win_now;
          end
        end
        if (last)
          st <= win_now ? (mover ? P2_WIN : P1_WIN) : (cnt == NN) ? DRAW : (mover ? P1_TURN : P2_TURN);
      end
`ifdef GAME_MGR_UNDO_EN
      else if (bus.btn_undo) begin
        if (lv) begin
          if (lm) g2[lc] <= 1'b0;
          else g1[lc] <= 1'b0;
          cnt <= cnt - 7'd1;
          st <= lm ? P2_TURN : P1_TURN;
          lv <= 1'b0;
        end
      end
`endif
      else if (bus.btn_s) begin
        if (st == P1_TURN || st == P2_TURN) begin
          if (g1[cidx] || g2[cidx]) ill <= 1'b1;
          else begin
            if (st == P2_TURN) g2[cidx] <= 1'b1;
            else g1[cidx] <= 1'b1;
            cnt <= cnt + 7'd1;
            mover <= st == P2_TURN;
            wx <= cx;
            wy <= cy;
            px <= {2'b00, cx};
            py <= {2'b00, cy};
            dir <= '0;
            back <= 1'b0;
            sc <= '0;
            live <= 1'b1;
            run <= 4'd1;
            won <= 1'b0;
            st <= CHECK;
`ifdef GAME_MGR_UNDO_EN
            lv <= 1'b1;
            lm <= st == P2_TURN;
            lc <= cidx;
`endif
          end
        end
      end
      else if (bus.btn_u) cy <= (cy == '0) ? XM : cy - 1'b1;
      else if (bus.btn_d) cy <= (cy == XM) ? '0 : cy + 1'b1;
      else if (bus.btn_l) cx <= (cx == '0) ? XM : cx - 1'b1;
      else if (bus.btn_r) cx <= (cx == XM) ? '0 : cx + 1'b1;
    end
  end
  assign bus.p1_grid = g1;
  assign bus.p2_grid = g2;
  assign bus.cursor_x = cx;
  assign bus.cursor_y = cy;
  assign bus.game_state = st;
  assign bus.move_count = cnt;
  assign bus.illegal = ill;
endmodule
